// File: rtl/rob_pkg.sv
// Shared types and constants for the reorder buffer.
//   rob_entry_t : one ROB slot at the default result/register widths
//   ROB_DEPTH   : default number of entries
//   rob_ptr_w() : head/tail pointer width (index bits plus one wrap bit)
package rob_pkg;

    localparam int unsigned ROB_DEPTH  = 32;
    localparam int unsigned ROB_DATA_W = 32;
    localparam int unsigned ROB_RD_W   = 5;

    typedef struct packed {
        logic                  valid;
        logic                  done;
        logic [ROB_RD_W-1:0]   rd;
        logic [ROB_DATA_W-1:0] data;
    } rob_entry_t;

    // Pointer width: enough bits to index DEPTH entries, plus the wrap bit
    function automatic int unsigned rob_ptr_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/rob_ptr.sv
// Wrap-bit pointer register for the ROB head or tail.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_flush        : synchronous return to zero (takes priority over i_inc)
//   i_inc          : advance by one, wrapping modulo 2^PTR_W
//   o_ptr          : registered pointer value
module rob_ptr #(
    parameter int unsigned PTR_W = 6
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_inc,
    output logic [PTR_W-1:0] o_ptr
);

    logic [PTR_W-1:0] r_ptr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= '0;
        end else if (i_flush) begin
            r_ptr <= '0;
        end else if (i_inc) begin
            r_ptr <= r_ptr + PTR_W'(1);
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/rob_tracker.sv
// Reorder buffer: allocates tags at dispatch, marks completion from the CDB,
// retires in program order through a valid/ready handshake.
// Optional feature: define ROB_OPERAND_LOOKUP_EN for combinational operand
// lookup with same-cycle CDB bypass; otherwise lookup outputs are tied to 0.
//   i_clk, i_rst_n, i_flush          : clock, async reset, mispredict flush
//   i_alloc_* / o_alloc_*            : dispatch allocation, tag = tail index
//   i_cdb_*                          : completion broadcast
//   o_retire_* / i_retire_ready      : head entry to commit
//   i_rsN_tag / o_rsN_hit / o_rsN_data : operand lookup
//   o_full, o_empty, o_count         : occupancy
module rob_tracker
    import rob_pkg::*;
#(
    parameter int unsigned DEPTH  = ROB_DEPTH,
    parameter int unsigned DATA_W = ROB_DATA_W,
    parameter int unsigned RD_W   = ROB_RD_W
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_flush,
    input  logic                         i_alloc_valid,
    input  logic [RD_W-1:0]              i_alloc_rd,
    output logic                         o_alloc_ready,
    output logic [$clog2(DEPTH)-1:0]     o_alloc_tag,
    input  logic                         i_cdb_valid,
    input  logic [$clog2(DEPTH)-1:0]     i_cdb_tag,
    input  logic [DATA_W-1:0]            i_cdb_data,
    output logic                         o_retire_valid,
    input  logic                         i_retire_ready,
    output logic [$clog2(DEPTH)-1:0]     o_retire_tag,
    output logic [RD_W-1:0]              o_retire_rd,
    output logic [DATA_W-1:0]            o_retire_data,
    input  logic [$clog2(DEPTH)-1:0]     i_rs1_tag,
    input  logic [$clog2(DEPTH)-1:0]     i_rs2_tag,
    output logic                         o_rs1_hit,
    output logic                         o_rs2_hit,
    output logic [DATA_W-1:0]            o_rs1_data,
    output logic [DATA_W-1:0]            o_rs2_data,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH):0]       o_count
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = rob_ptr_w(DEPTH);

    logic [PTR_W-1:0]  w_head;
    logic [PTR_W-1:0]  w_tail;
    logic [PTR_W-1:0]  w_count;
    logic [IDX_W-1:0]  w_head_idx;
    logic [IDX_W-1:0]  w_tail_idx;
    logic              w_full;
    logic              w_empty;
    logic              w_alloc_fire;
    logic              w_retire_fire;
    logic              w_cdb_hit;
    logic              w_retire_valid;

    logic [DEPTH-1:0]  r_valid;
    logic [DEPTH-1:0]  r_done;
    logic [RD_W-1:0]   r_rd   [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];

    // Occupancy decode from the registered pointers
    assign w_count    = w_tail - w_head;
    assign w_full     = (w_count == PTR_W'(DEPTH));
    assign w_empty    = (w_count == '0);
    assign w_head_idx = w_head[IDX_W-1:0];
    assign w_tail_idx = w_tail[IDX_W-1:0];

    // Flush wins over every other operation; full is judged before the edge
    assign w_retire_valid = !w_empty && r_done[w_head_idx];
    assign w_alloc_fire   = i_alloc_valid && !w_full && !i_flush;
    assign w_retire_fire  = w_retire_valid && i_retire_ready && !i_flush;
    assign w_cdb_hit      = i_cdb_valid && r_valid[i_cdb_tag] && !i_flush;

    rob_ptr #(.PTR_W(PTR_W)) u_head (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_flush (i_flush),
        .i_inc   (w_retire_fire),
        .o_ptr   (w_head)
    );

    rob_ptr #(.PTR_W(PTR_W)) u_tail (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_flush (i_flush),
        .i_inc   (w_alloc_fire),
        .o_ptr   (w_tail)
    );

    // Per-entry status write-enable decode
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= '0;
            r_done  <= '0;
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (i_flush) begin
                    r_valid[i] <= 1'b0;
                    r_done[i]  <= 1'b0;
                end else begin
                    if (w_cdb_hit && (i_cdb_tag == IDX_W'(i))) begin
                        r_done[i] <= 1'b1;
                    end
                    if (w_retire_fire && (w_head_idx == IDX_W'(i))) begin
                        r_valid[i] <= 1'b0;
                        r_done[i]  <= 1'b0;
                    end
                    if (w_alloc_fire && (w_tail_idx == IDX_W'(i))) begin
                        r_valid[i] <= 1'b1;
                        r_done[i]  <= 1'b0;
                    end
                end
            end
        end
    end

    // Payload storage; contents are meaningless until allocated, so no reset
    always_ff @(posedge i_clk) begin
        if (w_alloc_fire) begin
            r_rd[w_tail_idx] <= i_alloc_rd;
        end
        if (w_cdb_hit) begin
            r_data[i_cdb_tag] <= i_cdb_data;
        end
    end

    assign o_alloc_ready  = !w_full;
    assign o_alloc_tag    = w_tail_idx;
    assign o_full         = w_full;
    assign o_empty        = w_empty;
    assign o_count        = w_count;
    assign o_retire_valid = w_retire_valid;
    assign o_retire_tag   = w_head_idx;
    assign o_retire_rd    = r_rd[w_head_idx];
    assign o_retire_data  = r_data[w_head_idx];

`ifdef ROB_OPERAND_LOOKUP_EN
    logic w_rs1_bypass;
    logic w_rs2_bypass;

    // Same-cycle CDB result counts as available and overrides stored data
    assign w_rs1_bypass = i_cdb_valid && (i_cdb_tag == i_rs1_tag);
    assign w_rs2_bypass = i_cdb_valid && (i_cdb_tag == i_rs2_tag);
    assign o_rs1_hit    = r_valid[i_rs1_tag] && (r_done[i_rs1_tag] || w_rs1_bypass);
    assign o_rs2_hit    = r_valid[i_rs2_tag] && (r_done[i_rs2_tag] || w_rs2_bypass);
    assign o_rs1_data   = w_rs1_bypass ? i_cdb_data : r_data[i_rs1_tag];
    assign o_rs2_data   = w_rs2_bypass ? i_cdb_data : r_data[i_rs2_tag];
`else
    logic w_unused_lookup;

    assign w_unused_lookup = ^{i_rs1_tag, i_rs2_tag};
    assign o_rs1_hit       = 1'b0;
    assign o_rs2_hit       = 1'b0;
    assign o_rs1_data      = '0;
    assign o_rs2_data      = '0;
`endif

endmodule

// File: tb/tb_rob_tracker.sv
// Directed self-checking bench for rob_tracker (DEPTH=32, DATA_W=32, RD_W=5).
module tb_rob_tracker;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        alloc_valid;
    logic [4:0]  alloc_rd;
    logic        alloc_ready;
    logic [4:0]  alloc_tag;
    logic        cdb_valid;
    logic [4:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        retire_valid;
    logic        retire_ready;
    logic [4:0]  retire_tag;
    logic [4:0]  retire_rd;
    logic [31:0] retire_data;
    logic [4:0]  rs1_tag;
    logic [4:0]  rs2_tag;
    logic        rs1_hit;
    logic        rs2_hit;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        full;
    logic        empty;
    logic [5:0]  count;

    int errors = 0;
    int checks = 0;

    rob_tracker dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_flush        (flush),
        .i_alloc_valid  (alloc_valid),
        .i_alloc_rd     (alloc_rd),
        .o_alloc_ready  (alloc_ready),
        .o_alloc_tag    (alloc_tag),
        .i_cdb_valid    (cdb_valid),
        .i_cdb_tag      (cdb_tag),
        .i_cdb_data     (cdb_data),
        .o_retire_valid (retire_valid),
        .i_retire_ready (retire_ready),
        .o_retire_tag   (retire_tag),
        .o_retire_rd    (retire_rd),
        .o_retire_data  (retire_data),
        .i_rs1_tag      (rs1_tag),
        .i_rs2_tag      (rs2_tag),
        .o_rs1_hit      (rs1_hit),
        .o_rs2_hit      (rs2_hit),
        .o_rs1_data     (rs1_data),
        .o_rs2_data     (rs2_data),
        .o_full         (full),
        .o_empty        (empty),
        .o_count        (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush        = 1'b0;
        alloc_valid  = 1'b0;
        alloc_rd     = '0;
        cdb_valid    = 1'b0;
        cdb_tag      = '0;
        cdb_data     = '0;
        retire_ready = 1'b0;
        rs1_tag      = '0;
        rs2_tag      = '0;
    endtask

    task automatic do_flush();
        idle_inputs();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic alloc_n(input int n);
        for (int i = 0; i < n; i++) begin
            alloc_valid = 1'b1;
            alloc_rd    = 5'(i + 1);
            tick();
        end
        alloc_valid = 1'b0;
    endtask

    task automatic cdb_write(input logic [4:0] tag, input logic [31:0] data);
        cdb_valid = 1'b1;
        cdb_tag   = tag;
        cdb_data  = data;
        tick();
        cdb_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #12;
        if (alloc_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%0b exp=1", alloc_ready); end
        checks++;
        if (alloc_tag !== 5'd0) begin errors++; $display("FAIL reset_tag got=%0d exp=0", alloc_tag); end
        checks++;
        if (retire_valid !== 1'b0) begin errors++; $display("FAIL reset_retire_valid got=%0b exp=0", retire_valid); end
        checks++;
        if (full !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL reset_flags got full=%0b empty=%0b exp full=0 empty=1", full, empty); end
        checks++;
        if (count !== 6'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++;
        if (rs1_hit !== 1'b0 || rs2_hit !== 1'b0) begin errors++; $display("FAIL reset_hits got=%0b%0b exp=00", rs1_hit, rs2_hit); end
        checks++;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_alloc();
        for (int i = 0; i < 4; i++) begin
            if (alloc_tag !== 5'(i)) begin errors++; $display("FAIL alloc_tag_%0d got=%0d exp=%0d", i, alloc_tag, i); end
            checks++;
            alloc_valid = 1'b1;
            alloc_rd    = 5'(i + 1);
            tick();
        end
        alloc_valid = 1'b0;
        if (count !== 6'd4) begin errors++; $display("FAIL alloc_count got=%0d exp=4", count); end
        checks++;
        if (retire_valid !== 1'b0) begin errors++; $display("FAIL alloc_retire_valid got=%0b exp=0", retire_valid); end
        checks++;
        if (empty !== 1'b0) begin errors++; $display("FAIL alloc_empty got=%0b exp=0", empty); end
        checks++;
    endtask

    task automatic test_cdb_retire();
        cdb_write(5'd2, 32'hAA);
        if (retire_valid !== 1'b0) begin errors++; $display("FAIL cdb_ooo_no_retire got=%0b exp=0", retire_valid); end
        checks++;
        cdb_write(5'd0, 32'h11);
        if (retire_valid !== 1'b1 || retire_tag !== 5'd0 || retire_data !== 32'h11 || retire_rd !== 5'd1) begin
            errors++;
            $display("FAIL retire_head0 got v=%0b tag=%0d data=%0h rd=%0d exp v=1 tag=0 data=11 rd=1",
                     retire_valid, retire_tag, retire_data, retire_rd);
        end
        checks++;
        retire_ready = 1'b1;
        tick();
        if (retire_valid !== 1'b0 || retire_tag !== 5'd1 || count !== 6'd3) begin
            errors++;
            $display("FAIL retire_wait1 got v=%0b tag=%0d count=%0d exp v=0 tag=1 count=3", retire_valid, retire_tag, count);
        end
        checks++;
        retire_ready = 1'b0;
        cdb_write(5'd1, 32'h22);
        if (retire_valid !== 1'b1 || retire_data !== 32'h22 || retire_rd !== 5'd2) begin
            errors++;
            $display("FAIL retire_head1 got v=%0b data=%0h rd=%0d exp v=1 data=22 rd=2", retire_valid, retire_data, retire_rd);
        end
        checks++;
        retire_ready = 1'b1;
        tick();
        if (retire_valid !== 1'b1 || retire_tag !== 5'd2 || retire_data !== 32'hAA) begin
            errors++;
            $display("FAIL retire_head2 got v=%0b tag=%0d data=%0h exp v=1 tag=2 data=aa", retire_valid, retire_tag, retire_data);
        end
        checks++;
        tick();
        retire_ready = 1'b0;
        if (retire_valid !== 1'b0 || retire_tag !== 5'd3 || count !== 6'd1) begin
            errors++;
            $display("FAIL retire_stop3 got v=%0b tag=%0d count=%0d exp v=0 tag=3 count=1", retire_valid, retire_tag, count);
        end
        checks++;
    endtask

    task automatic test_full_wrap();
        do_flush();
        for (int i = 0; i < 32; i++) begin
            alloc_valid = 1'b1;
            alloc_rd    = 5'(i);
            tick();
        end
        if (full !== 1'b1 || alloc_ready !== 1'b0 || count !== 6'd32) begin
            errors++;
            $display("FAIL full_flags got full=%0b ready=%0b count=%0d exp 1 0 32", full, alloc_ready, count);
        end
        checks++;
        tick();
        alloc_valid = 1'b0;
        if (count !== 6'd32) begin errors++; $display("FAIL full_reject got=%0d exp=32", count); end
        checks++;
        cdb_write(5'd0, 32'h77);
        if (retire_valid !== 1'b1 || retire_data !== 32'h77) begin
            errors++;
            $display("FAIL full_head_ready got v=%0b data=%0h exp v=1 data=77", retire_valid, retire_data);
        end
        checks++;
        alloc_valid  = 1'b1;
        alloc_rd     = 5'd9;
        retire_ready = 1'b1;
        tick();
        retire_ready = 1'b0;
        if (count !== 6'd31 || full !== 1'b0 || alloc_tag !== 5'd0 || retire_tag !== 5'd1) begin
            errors++;
            $display("FAIL full_alloc_retire got count=%0d full=%0b tag=%0d head=%0d exp 31 0 0 1", count, full, alloc_tag, retire_tag);
        end
        checks++;
        tick();
        alloc_valid = 1'b0;
        if (count !== 6'd32 || full !== 1'b1 || alloc_tag !== 5'd1) begin
            errors++;
            $display("FAIL wrap_alloc got count=%0d full=%0b tag=%0d exp 32 1 1", count, full, alloc_tag);
        end
        checks++;
    endtask

    task automatic test_flush();
        do_flush();
        alloc_n(10);
        if (count !== 6'd10) begin errors++; $display("FAIL flush_pre_count got=%0d exp=10", count); end
        checks++;
        flush       = 1'b1;
        alloc_valid = 1'b1;
        alloc_rd    = 5'd7;
        cdb_valid   = 1'b1;
        cdb_tag     = 5'd0;
        cdb_data    = 32'h33;
        tick();
        flush       = 1'b0;
        alloc_valid = 1'b0;
        cdb_valid   = 1'b0;
        if (count !== 6'd0 || empty !== 1'b1 || alloc_tag !== 5'd0 || alloc_ready !== 1'b1 || retire_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_state got count=%0d empty=%0b tag=%0d ready=%0b rv=%0b exp 0 1 0 1 0",
                     count, empty, alloc_tag, alloc_ready, retire_valid);
        end
        checks++;
        alloc_valid = 1'b1;
        alloc_rd    = 5'd3;
        tick();
        alloc_valid = 1'b0;
        if (count !== 6'd1 || alloc_tag !== 5'd1 || retire_rd !== 5'd3 || retire_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_realloc got count=%0d tag=%0d rd=%0d rv=%0b exp 1 1 3 0", count, alloc_tag, retire_rd, retire_valid);
        end
        checks++;
        cdb_write(5'd5, 32'h44);
        if (retire_valid !== 1'b0) begin errors++; $display("FAIL cdb_unalloc got=%0b exp=0", retire_valid); end
        checks++;
    endtask

    task automatic test_lookup();
        do_flush();
        alloc_n(5);
        rs1_tag   = 5'd3;
        rs2_tag   = 5'd7;
        cdb_valid = 1'b1;
        cdb_tag   = 5'd3;
        cdb_data  = 32'h5;
        #1;
`ifdef ROB_OPERAND_LOOKUP_EN
        if (rs1_hit !== 1'b1 || rs1_data !== 32'h5) begin
            errors++; $display("FAIL lookup_bypass got hit=%0b data=%0h exp 1 5", rs1_hit, rs1_data);
        end
        checks++;
        if (rs2_hit !== 1'b0) begin errors++; $display("FAIL lookup_unalloc got=%0b exp=0", rs2_hit); end
        checks++;
        tick();
        cdb_valid = 1'b0;
        #1;
        if (rs1_hit !== 1'b1 || rs1_data !== 32'h5) begin
            errors++; $display("FAIL lookup_stored got hit=%0b data=%0h exp 1 5", rs1_hit, rs1_data);
        end
        checks++;
        rs1_tag = 5'd2;
        #1;
        if (rs1_hit !== 1'b0) begin errors++; $display("FAIL lookup_not_done got=%0b exp=0", rs1_hit); end
        checks++;
`else
        if (rs1_hit !== 1'b0 || rs1_data !== 32'h0 || rs2_hit !== 1'b0 || rs2_data !== 32'h0) begin
            errors++;
            $display("FAIL lookup_disabled got hit1=%0b d1=%0h hit2=%0b d2=%0h exp all 0", rs1_hit, rs1_data, rs2_hit, rs2_data);
        end
        checks++;
        tick();
        cdb_valid = 1'b0;
        #1;
        if (rs1_hit !== 1'b0 || rs1_data !== 32'h0) begin
            errors++; $display("FAIL lookup_disabled_stored got hit=%0b data=%0h exp 0 0", rs1_hit, rs1_data);
        end
        checks++;
`endif
        idle_inputs();
    endtask

    task automatic test_async_reset();
        do_flush();
        alloc_n(7);
        cdb_write(5'd0, 32'h99);
        if (count !== 6'd7 || retire_valid !== 1'b1) begin
            errors++; $display("FAIL areset_pre got count=%0d rv=%0b exp 7 1", count, retire_valid);
        end
        checks++;
        #2;
        rst_n = 1'b0;
        #1;
        if (count !== 6'd0 || empty !== 1'b1 || full !== 1'b0 || alloc_ready !== 1'b1 ||
            alloc_tag !== 5'd0 || retire_valid !== 1'b0 || rs1_hit !== 1'b0 || rs2_hit !== 1'b0) begin
            errors++;
            $display("FAIL areset_state got count=%0d empty=%0b full=%0b ready=%0b tag=%0d rv=%0b exp 0 1 0 1 0 0",
                     count, empty, full, alloc_ready, alloc_tag, retire_valid);
        end
        checks++;
        #1;
        rst_n = 1'b1;
        tick();
        if (count !== 6'd0 || retire_valid !== 1'b0) begin
            errors++; $display("FAIL areset_release got count=%0d rv=%0b exp 0 0", count, retire_valid);
        end
        checks++;
    endtask

    initial begin
        rst_n = 1'b1;
        idle_inputs();
        test_reset();
        test_alloc();
        test_cdb_retire();
        test_full_wrap();
        test_flush();
        test_lookup();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
